// File: rtl/sweep_real.sv
// sweep_real: fixed-point triangle sweep LO->HI->LO, one sample per
// valid/ready transfer, for n_cycles full cycles (0 = forever).
//
// Parameters: WIDTH sample width, EXPONENT LSB weight (value = out*2^EXP),
//   LO/HI bounds (integer codes), STEP increment, CNT_W cycle counter width.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start, stop      begin request / abort (stop wins)
//   n_cycles         full cycles to run, latched on accepted start
//   out, out_valid   sample and its valid
//   out_ready        downstream ready
//   busy, done       not idle / one-cycle finite-sweep completion pulse
// Optional: define SWEEP_REAL_CHECK_EN for a simulation-only range monitor
//   and elaboration parameter checks.
module sweep_real #(
  parameter int WIDTH    = 16,
  parameter int EXPONENT = -8,
  parameter int LO       = -1024,
  parameter int HI       = 1024,
  parameter int STEP     = 64,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CNT_W-1:0]        n_cycles,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_LAST = 2'd3
  } state_t;

  localparam logic signed [WIDTH-1:0] LO_W = WIDTH'(LO);
  localparam logic signed [WIDTH-1:0] HI_W = WIDTH'(HI);
  localparam logic signed [WIDTH:0] LO_X = (WIDTH+1)'(LO);
  localparam logic signed [WIDTH:0] HI_X = (WIDTH+1)'(HI);
  localparam logic signed [WIDTH:0] ST_X = (WIDTH+1)'(STEP);

  state_t r_state, w_state_d;
  logic signed [WIDTH-1:0] r_out, w_out_d;
  logic r_vld, w_vld_d;
  logic r_done, w_done_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] r_ncyc, w_ncyc_d;

  logic w_xfer;
  logic signed [WIDTH:0] w_up;
  logic signed [WIDTH:0] w_dn;
  logic [CNT_W-1:0] w_cnt_inc;

  // One extra bit keeps out +/- STEP from wrapping near the rails.
  assign w_xfer = r_vld & out_ready;
  assign w_up = {r_out[WIDTH-1], r_out} + ST_X;
  assign w_dn = {r_out[WIDTH-1], r_out} - ST_X;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_out   <= LO_W;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_ncyc  <= '0;
    end else begin
      r_state <= w_state_d;
      r_out   <= w_out_d;
      r_vld   <= w_vld_d;
      r_done  <= w_done_d;
      r_cnt   <= w_cnt_d;
      r_ncyc  <= w_ncyc_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_out_d   = r_out;
    w_vld_d   = r_vld;
    w_done_d  = 1'b0;
    w_cnt_d   = r_cnt;
    w_ncyc_d  = r_ncyc;
    if (stop) begin
      // Abort: any same-cycle transfer still counts, out holds.
      w_state_d = S_IDLE;
      w_vld_d   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_out_d   = LO_W;
            w_cnt_d   = '0;
            w_ncyc_d  = n_cycles;
            w_vld_d   = 1'b1;
            w_state_d = S_UP;
          end
        end
        S_UP: begin
          if (w_xfer) begin
            if (w_up >= HI_X) begin
              w_out_d   = HI_W;
              w_state_d = S_DOWN;
            end else begin
              w_out_d = w_up[WIDTH-1:0];
            end
          end
        end
        S_DOWN: begin
          if (w_xfer) begin
            if (w_dn <= LO_X) begin
              w_out_d = LO_W;
              w_cnt_d = w_cnt_inc;
              if (r_ncyc != '0 && w_cnt_inc == r_ncyc) begin
                w_state_d = S_LAST;
              end else begin
                w_state_d = S_UP;
              end
            end else begin
              w_out_d = w_dn[WIDTH-1:0];
            end
          end
        end
        S_LAST: begin
          if (w_xfer) begin
            w_vld_d   = 1'b0;
            w_done_d  = 1'b1;
            w_state_d = S_IDLE;
          end
        end
        default: begin
          w_state_d = S_IDLE;
          w_vld_d   = 1'b0;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_vld;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

`ifdef SWEEP_REAL_CHECK_EN
  real m_scale;
  real m_val;
  real m_lo;
  real m_hi;

  initial begin
    if (LO >= HI || STEP <= 0 || STEP > HI - LO) begin
      $fatal(1, "sweep_real: bad parameters LO=%0d HI=%0d STEP=%0d",
             LO, HI, STEP);
    end
  end

  always @(out) begin
    m_scale = 2.0 ** EXPONENT;
    m_val = $itor(out) * m_scale;
    m_lo = $itor(LO) * m_scale;
    m_hi = $itor(HI) * m_scale;
    if (busy && (m_val < m_lo || m_val > m_hi)) begin
      $display("sweep_real: out %f outside [%f, %f]", m_val, m_lo, m_hi);
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_sweep_real.sv
// tb_sweep_real: scoreboard bench for sweep_real with LO=-4 HI=4 STEP=3.
// Expected samples come from a small behavioural model pushed to a queue.
module tb_sweep_real;

  localparam int W = 16;
  localparam int LO = -4;
  localparam int HI = 4;
  localparam int STEP = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic out_ready = 1'b1;
  logic [CW-1:0] n_cycles = '0;
  logic signed [W-1:0] out;
  logic out_valid;
  logic busy;
  logic done;

  int total = 0;
  int bad = 0;
  int q[$];

  sweep_real #(
    .WIDTH(W), .EXPONENT(-8), .LO(LO), .HI(HI), .STEP(STEP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .n_cycles(n_cycles), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Triangle model: LO first, HI at each peak, LO at each trough.
  task automatic push_model(input int ncyc, input int limit);
    int v;
    int c;
    v = LO;
    c = 0;
    q.push_back(v);
    while (q.size() < limit) begin
      while (v + STEP < HI && q.size() < limit) begin
        v += STEP;
        q.push_back(v);
      end
      if (q.size() >= limit) break;
      v = HI;
      q.push_back(v);
      while (v - STEP > LO && q.size() < limit) begin
        v -= STEP;
        q.push_back(v);
      end
      if (q.size() >= limit) break;
      v = LO;
      q.push_back(v);
      c++;
      if (ncyc != 0 && c == ncyc) break;
    end
  endtask

  task automatic abort_run();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (out !== W'(LO) || out_valid !== 1'b0 || busy !== 1'b0
        || done !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%0d vld=%b busy=%b done=%b want %0d/0/0/0",
               out, out_valid, busy, done, LO);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e;
    q.delete();
    push_model(1, 100);
    @(negedge clk);
    n_cycles = 8'd1;
    start = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      e = (q.size() > 0) ? q.pop_front() : 9999;
      total++;
      if (out_valid !== 1'b1 || out !== W'(e) || done !== 1'b0) begin
        bad++;
        $display("FAIL basic[%0d]: out=%0d vld=%b done=%b want %0d/1/0",
                 i, out, out_valid, done, e);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0
        || q.size() != 0) begin
      bad++;
      $display("FAIL basic_done: done=%b busy=%b vld=%b left=%0d want 1/0/0/0",
               done, busy, out_valid, q.size());
    end
    // Start in the done cycle must be accepted.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1
        || out !== W'(LO)) begin
      bad++;
      $display("FAIL back_to_back: done=%b busy=%b vld=%b out=%0d want 0/1/1/%0d",
               done, busy, out_valid, out, LO);
    end
    abort_run();
  endtask

  task automatic test_two_cycles();
    int e;
    q.delete();
    push_model(2, 100);
    @(negedge clk);
    n_cycles = 8'd2;
    start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      start = 1'b0;
      e = (q.size() > 0) ? q.pop_front() : 9999;
      total++;
      if (out_valid !== 1'b1 || out !== W'(e) || done !== 1'b0) begin
        bad++;
        $display("FAIL two_cycles[%0d]: out=%0d vld=%b done=%b want %0d/1/0",
                 i, out, out_valid, done, e);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL two_cycles_done: done=%b busy=%b want 1/0", done, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_width: done=%b want 0", done);
    end
  endtask

  task automatic test_backpressure();
    int e;
    q.delete();
    push_model(1, 100);
    @(negedge clk);
    n_cycles = 8'd1;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = !(c >= 3 && c <= 5);
      total++;
      if (out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 9999;
        if (out_valid !== 1'b1 || out !== W'(e)) begin
          bad++;
          $display("FAIL bp[%0d]: out=%0d vld=%b want %0d/1",
                   c, out, out_valid, e);
        end
      end else begin
        e = (q.size() > 0) ? q[0] : 9999;
        if (out_valid !== 1'b1 || out !== W'(e) || e != 2) begin
          bad++;
          $display("FAIL bp_hold[%0d]: out=%0d vld=%b want 2/1",
                   c, out, out_valid);
        end
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || q.size() != 0) begin
      bad++;
      $display("FAIL bp_done: done=%b left=%0d want 1/0", done, q.size());
    end
  endtask

  task automatic test_infinite();
    int e;
    q.delete();
    push_model(0, 30);
    @(negedge clk);
    n_cycles = 8'd0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      e = (q.size() > 0) ? q.pop_front() : 9999;
      total++;
      if (out_valid !== 1'b1 || out !== W'(e) || done !== 1'b0
          || busy !== 1'b1) begin
        bad++;
        $display("FAIL inf[%0d]: out=%0d vld=%b done=%b want %0d/1/0",
                 i, out, out_valid, done, e);
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL inf_stop: vld=%b busy=%b done=%b want 0/0/0",
               out_valid, busy, done);
    end
  endtask

  task automatic test_stop();
    int e;
    @(negedge clk);
    n_cycles = 8'd1;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stop_start: busy=%b vld=%b want 0/0", busy, out_valid);
    end
    q.delete();
    push_model(1, 4);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      e = (q.size() > 0) ? q.pop_front() : 9999;
      total++;
      if (out_valid !== 1'b1 || out !== W'(e)) begin
        bad++;
        $display("FAIL stop_run[%0d]: out=%0d vld=%b want %0d/1",
                 i, out, out_valid, e);
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out !== 16'sd4 || busy !== 1'b0
        || done !== 1'b0) begin
      bad++;
      $display("FAIL stop_abort: out=%0d vld=%b busy=%b done=%b want 4/0/0/0",
               out, out_valid, busy, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || out !== 16'sd4) begin
      bad++;
      $display("FAIL stop_nodone: done=%b out=%0d want 0/4", done, out);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out !== W'(LO)) begin
      bad++;
      $display("FAIL stop_restart: out=%0d vld=%b want %0d/1",
               out, out_valid, LO);
    end
    abort_run();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    n_cycles = 8'd1;
    start = 1'b1;
    repeat (2) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== W'(LO) || out_valid !== 1'b0 || busy !== 1'b0
        || done !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: out=%0d vld=%b busy=%b done=%b want %0d/0/0/0",
               out, out_valid, busy, done, LO);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_cycles();
    test_backpressure();
    test_infinite();
    test_stop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sweep_real.md
# sweep_real

Synchronous fixed-point triangle-sweep source for the svreal domain. It drives a real-valued signal monotonically between a declared lower and upper bound, one sample per valid/ready transfer, for a programmable number of full cycles. It sits upstream of real-valued datapaths and range checkers as the stimulus-side counterpart to range assertion. Every sample it emits lies within its declared range by construction.

## Interface
Parameters:
- `WIDTH`, 16: signed sample width. The real value is `out * 2^EXPONENT`.
- `EXPONENT`, -8: LSB weight exponent.
- `LO`, -1024: lower bound, signed integer code.
- `HI`, 1024: upper bound, signed integer code. Must satisfy `LO < HI`.
- `STEP`, 64: step size, integer code. Must satisfy `0 < STEP <= HI-LO`.
- `CNT_W`, 8: width of the cycle counter.

Ports:
- `clk`, input, 1: the only clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: single-cycle request to begin a sweep.
- `stop`, input, 1: abort request.
- `n_cycles`, input, `CNT_W`: number of full LO→HI→LO cycles. Sampled on accepted `start`. A value of 0 means run forever.
- `out`, output, `WIDTH` signed: current sample code.
- `out_valid`, output, 1: `out` holds a sample.
- `out_ready`, input, 1: downstream accepts the sample.
- `busy`, output, 1: state is not IDLE.
- `done`, output, 1: one-cycle pulse when a finite sweep completes.

## Operation
- The FSM has four states: IDLE, UP, DOWN, LAST.
- A transfer is `out_valid && out_ready` on a rising edge of `clk`.
- All arithmetic uses `WIDTH+1` bits with sign extension, so `out±STEP` cannot wrap.
- IDLE:
  - `out_valid` is 0.
  - `start` loads `out←LO`, clears the counter, latches `n_cycles`, sets `out_valid←1`, and moves to UP.
- UP, on transfer:
  - If `out+STEP >= HI`: `out←HI`, move to DOWN.
  - Otherwise: `out←out+STEP`.
- DOWN, on transfer:
  - If `out-STEP <= LO`: `out←LO`, counter increments.
  - If the latched `n_cycles ≠ 0` and the new count equals it, move to LAST. Otherwise move to UP.
  - If neither condition applies: `out←out-STEP`.
- LAST, on transfer:
  - `out_valid←0`, `done←1` for one cycle, move to IDLE.
  - `out` holds LO.
- No transfer: `out` and `out_valid` hold (backpressure). Values must remain stable while `out_valid && !out_ready`.
- `stop`:
  - Valid in any state and highest priority.
  - Next state is IDLE, `out_valid←0`, no `done` pulse, `out` holds its value.
  - `stop` and a transfer in the same cycle: the sample counts as transferred, then the sweep aborts.
- `start` while `busy` is ignored. `start` and `stop` together: `stop` wins.
- Counter:
  - Saturates at all-ones when `n_cycles=0`, which only matters for observation.
  - It does not affect the infinite sweep.
- The bounds are always emitted exactly (LO first, HI at each peak, LO at each trough), even when `HI-LO` is not a multiple of `STEP`.

## Timing
- Reset values:
  - `out=LO`, `out_valid=0`, `busy=0`, `done=0`.
  - State IDLE, counter 0.
- Reset is asynchronous on assertion. Mid-sweep reset returns all of the above immediately, with no `done`.
- `start` accepted at edge k gives `out_valid=1` and `out=LO` after edge k.
- One sample per cycle when `out_ready` is held high. The next sample is visible the cycle after the transfer.
- `done` is asserted the cycle after the LAST transfer, for exactly one cycle. `busy` falls in that same cycle.
- A new `start` is accepted in the cycle `done` is high.

## Configuration
- `SWEEP_REAL_CHECK_EN` defined:
  - Compiles in a simulation-only monitor.
  - On every change of `out` while `busy`, if the real value `out*2^EXPONENT` is outside `[LO*2^EXPONENT, HI*2^EXPONENT]`, it prints the value and the bounds as reals, then calls `$finish`.
  - At elaboration it also calls `$fatal` if `LO>=HI` or `STEP<=0` or `STEP>HI-LO`.
- `SWEEP_REAL_CHECK_EN` undefined: no monitor or elaboration checks are present, and the logic is otherwise identical.

## Test plan
- Basic sweep:
  - Stimulus: `LO=-4`, `HI=4`, `STEP=3`, `n_cycles=1`, `out_ready=1`, `start` pulse.
  - Response: `out` = -4,-1,2,4,1,-2,-4 on consecutive cycles, `done` one cycle later, then `busy=0`.
- Backpressure:
  - Stimulus: same configuration, `out_ready` low for 3 cycles while `out=2`.
  - Response: `out` stays 2 with `out_valid=1` for those cycles, and the next sample is 4.
- Infinite mode:
  - Stimulus: `n_cycles=0`, run 30 transfers.
  - Response: the pattern repeats with period 6 (-4,-1,2,4,1,-2) and `done` never rises.
- Stop mid-sweep:
  - Stimulus: assert `stop` together with `start` for one cycle, then `stop` at `out=4` in DOWN.
  - Response: the first `start` is ignored. The abort gives `out_valid=0` next cycle, `out` holds 4, no `done`. A later `start` restarts at -4.
- Async reset:
  - Stimulus: drop `rst_n` mid-cycle during UP.
  - Response: `out=LO`, `out_valid=0`, `busy=0` without waiting for a `clk` edge.
- Check build:
  - Stimulus: compile with `SWEEP_REAL_CHECK_EN` and `STEP=0`.
  - Response: elaboration `$fatal`. Legal parameters run the basic sweep with no monitor message.
